// File: rtl/cmp_arbiter_if.sv
// Request, operand and result bundle between two requesters and cmp_arbiter.
// The eq result wire exists only when CMP_ARBITER_EQ_EN is defined.
interface cmp_arbiter_if #(
    parameter int WIDTH = 2
);
    logic [1:0]       req;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic [1:0]       gnt;
    logic [1:0]       done;
    logic             gt;
    logic             busy;
`ifdef CMP_ARBITER_EQ_EN
    logic             eq;

    modport master (output req, a0, b0, a1, b1, input gnt, done, gt, busy, eq);
    modport slave  (input req, a0, b0, a1, b1, output gnt, done, gt, busy, eq);
`else
    modport master (output req, a0, b0, a1, b1, input gnt, done, gt, busy);
    modport slave  (input req, a0, b0, a1, b1, output gnt, done, gt, busy);
`endif
endinterface

// File: rtl/cmp_arbiter.sv
// Two-requester round-robin arbiter sharing one unsigned greater-than comparator.
// Optional eq result is enabled by defining CMP_ARBITER_EQ_EN.
module cmp_arbiter #(
    parameter int WIDTH = 2
) (
    input logic          clk,
    input logic          rst,
    cmp_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, LATCH, EVAL, RESP} state_e;

    state_e           state_q, state_d;
    logic             sel_q, sel_d;
    logic             ptr_q, ptr_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [1:0]       done_q, done_d;
    logic             gt_q, gt_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             cmp_gt;
`ifdef CMP_ARBITER_EQ_EN
    logic             eq_q, eq_d;
`endif

    // The single shared comparator, fed only from the captured operands.
    assign cmp_gt = (op_a_q > op_b_q);

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        done_d  = done_q;
        gt_d    = gt_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
`ifdef CMP_ARBITER_EQ_EN
        eq_d    = eq_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req != 2'b00) begin
                    sel_d   = (bus.req == 2'b11) ? ptr_q : bus.req[1];
                    gnt_d   = sel_d ? 2'b10 : 2'b01;
                    state_d = LATCH;
                end
            end
            LATCH: begin
                op_a_d  = sel_q ? bus.a1 : bus.a0;
                op_b_d  = sel_q ? bus.b1 : bus.b0;
                gnt_d   = 2'b00;
                state_d = EVAL;
            end
            EVAL: begin
                gt_d    = cmp_gt;
`ifdef CMP_ARBITER_EQ_EN
                eq_d    = (op_a_q == op_b_q);
`endif
                done_d  = sel_q ? 2'b10 : 2'b01;
                state_d = RESP;
            end
            RESP: begin
                done_d  = 2'b00;
                ptr_d   = ~ptr_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            ptr_q   <= 1'b0;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            gt_q    <= 1'b0;
            busy_q  <= 1'b0;
`ifdef CMP_ARBITER_EQ_EN
            eq_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            gt_q    <= gt_d;
            busy_q  <= busy_d;
`ifdef CMP_ARBITER_EQ_EN
            eq_q    <= eq_d;
`endif
        end
        // NOTE: operand registers carry no reset; they are always loaded in LATCH before use.
        op_a_q <= op_a_d;
        op_b_q <= op_b_d;
    end

    assign bus.gnt  = gnt_q;
    assign bus.done = done_q;
    assign bus.gt   = gt_q;
    assign bus.busy = busy_q;
`ifdef CMP_ARBITER_EQ_EN
    assign bus.eq   = eq_q;
`endif

endmodule
